jtdsp16_sout: RTL and testbench

Parametrised multi-channel serial output unit for the DSP16 core family. It buffers CPU-written sample words in a small FIFO and serialises them with DSP16-style pins (ock/sdo/old/ose). It tracks the channel slot of every word within a frame so that stereo or multi-channel audio streams leave the chip frame-aligned. It sits between the CPU store path (accumulator, RAM or immediate writes to the serial output register) and the external DAC/serial pins, and it generalises the fixed 16-bit single-buffer serial output.

---
 rtl/jtdsp16_sout.sv | 118 +++++++++++
 tb/tb_jtdsp16_sout.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_sout.sv
// jtdsp16_sout: multi-channel DSP16-style serial output (ock/sdo/old/ose) fed by a word FIFO.
// Define JTDSP16_SOUT_UNDERRUN_EN to pad incomplete frames with zero words (FILL state).
module jtdsp16_sout #(
  parameter int DW = 16,
  parameter int CH = 2,
  parameter int AW = 2,
  parameter int CKDIV = 1,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          msb_first,
  input  logic          doen,
  input  logic          ovf_clr,
  output logic          ock,
  output logic          sdo,
  output logic          old,
  output logic          ose,
  output logic [CW-1:0] ch,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          unf
);
  localparam int BW = $clog2(DW);
  localparam int VW = CKDIV > 1 ? $clog2(CKDIV) : 1;
  localparam int LW = AW + 1;
`ifdef JTDSP16_SOUT_UNDERRUN_EN
  typedef enum logic [1:0] {IDLE, SHIFT, FILL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t st, st_ld;
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] sh, nsh, wd;
  logic          msb;
  logic [BW-1:0] bcnt;
  logic [VW-1:0] div;
  logic [CW-1:0] ch_nx;
  logic          half, wend, ld_idle, ld_end, pop, push, fill_go;
  assign full    = level[AW];
  assign empty   = level == '0;
  assign ose     = st == IDLE && empty;
  assign half    = div == VW'(CKDIV - 1);
  // a word ends when the high half of its last bit expires
  assign wend    = cen && st != IDLE && half && ock && bcnt == BW'(DW - 1);
  assign ch_nx   = ch == CW'(CH - 1) ? '0 : ch + 1'b1;
  assign ld_idle = cen && st == IDLE && !empty && doen;
  assign ld_end  = wend && st == SHIFT && !empty && doen;
  assign pop     = ld_idle || ld_end;
  assign push    = cen && wr && (!full || pop);
  assign wd      = pop ? mem[rptr] : '0;
  assign nsh     = msb ? sh << 1 : sh >> 1;
`ifdef JTDSP16_SOUT_UNDERRUN_EN
  // keep padding with zero words until the frame slot wraps back to 0
  assign fill_go = wend && ch_nx != '0 && (st == FILL || empty);
  assign st_ld   = pop ? SHIFT : FILL;
`else
  assign fill_go = 1'b0;
  assign st_ld   = SHIFT;
`endif
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      ock   <= 1'b0;
      sdo   <= 1'b0;
      old   <= 1'b0;
      ch    <= '0;
      sh    <= '0;
      msb   <= 1'b1;
      bcnt  <= '0;
      div   <= '0;
    end else if (cen) begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
      ovf   <= !ovf_clr && (ovf || (wr && full && !pop));
      unf   <= !ovf_clr && (unf || fill_go);
      if (wend) ch <= ch_nx;
      if (pop || fill_go) begin
        st   <= st_ld;
        sh   <= wd;
        msb  <= msb_first;
        sdo  <= msb_first ? wd[DW-1] : wd[0];
        bcnt <= '0;
        div  <= '0;
        ock  <= 1'b0;
        old  <= 1'b1;
      end else if (wend) begin
        st  <= IDLE;
        ock <= 1'b0;
        old <= 1'b0;
      end else if (st != IDLE) begin
        div <= half ? '0 : div + 1'b1;
        if (half) begin
          ock <= !ock;
          if (ock) begin
            sh   <= nsh;
            sdo  <= msb ? nsh[DW-1] : nsh[0];
            bcnt <= bcnt + 1'b1;
            old  <= 1'b0;
          end
        end
      end
    end
endmodule

// File: tb/tb_jtdsp16_sout.sv
// tb_jtdsp16_sout: randomized self-checking bench; expected pin streams are derived
// word-by-word from the frame/bit timing rules (32 ticks per 16-bit word, CKDIV=1).
module tb_jtdsp16_sout;
`ifdef JTDSP16_SOUT_UNDERRUN_EN
  localparam bit UND = 1'b1;
`else
  localparam bit UND = 1'b0;
`endif
  localparam int CH = 2;
  localparam logic [11:0] RST = 12'b0001_0100_0000;
  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b1, wr = 1'b0, msb_first = 1'b1, doen = 1'b1, ovf_clr = 1'b0;
  logic [15:0] din = '0;
  logic ock, sdo, old, ose, full, empty, ovf, unf;
  logic [0:0] ch;
  logic [2:0] level;
  logic [4:0] now;
  logic [11:0] rv;
  logic [4:0] ob [0:255];
  logic [4:0] ev [0:255];
  logic [2:0] lv [0:255];
  logic fl [0:255];
  logic ov [0:255];
  logic un [0:255];
  logic pv [0:255];
  logic [15:0] pd [0:255];
  int passed = 0, total = 0;

  jtdsp16_sout #(.DW(16), .CH(2), .AW(2), .CKDIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .din(din), .msb_first(msb_first),
    .doen(doen), .ovf_clr(ovf_clr), .ock(ock), .sdo(sdo), .old(old), .ose(ose), .ch(ch),
    .full(full), .empty(empty), .level(level), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;
  assign now = {ock, sdo, old, ch, ose};
  assign rv  = {ock, sdo, old, ose, ch, empty, full, level, ovf, unf};

  task automatic do_reset();
    wr = 1'b0; ovf_clr = 1'b0; doen = 1'b1;
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic clear_sched();
    for (int t = 0; t < 256; t++) begin
      pv[t] = 1'b0;
      pd[t] = '0;
    end
  endtask

  // drive the push schedule and capture pins after each of n edges
  task automatic record(input int n);
    for (int t = 0; t < n; t++) begin
      wr = pv[t]; din = pd[t];
      @(posedge clk); #1;
      ob[t] = now; lv[t] = level; fl[t] = full; ov[t] = ovf; un[t] = unf;
    end
    wr = 1'b0;
  endtask

  // reference: words leave back-to-back from tick s, 2 ticks per bit, slot counts modulo CH
  task automatic build(input logic [15:0] w[$], input bit m, input int s, input int c0, output int te);
    int n, j, k, b;
    logic bt;
    if (UND) while ((c0 + w.size()) % CH != 0) w.push_back(16'h0);
    n = w.size();
    te = s + 32 * n;
    for (int t = s; t < te; t++) begin
      j = (t - s) / 32; k = (t - s) % 32; b = k / 2;
      bt = m ? w[j][15-b] : w[j][b];
      ev[t] = {k[0], bt, b == 0, 1'((c0 + j) % CH), 1'b0};
    end
    bt = m ? w[n-1][0] : w[n-1][15];
    ev[te] = {1'b0, bt, 1'b0, 1'((c0 + n) % CH), 1'b1};
  endtask

  task automatic test_reset();
    total++;
    if (rv !== RST) $display("FAIL reset_values got %b expected %b", rv, RST);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(); clear_sched();
    pv[0] = 1'b1; pd[0] = 16'($urandom);
    record(12);
    #2 rst_n = 1'b0; #1;
    total++;
    if (rv !== RST) $display("FAIL async_reset got %b expected %b", rv, RST);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_sched(); record(40);
    for (int t = 0; t < 40; t++) begin
      total++;
      if (ob[t] !== 5'b00001 || lv[t] !== 3'd0)
        $display("FAIL no_resume t=%0d pins=%b level=%0d expected 00001/0", t, ob[t], lv[t]);
      else passed++;
    end
  endtask

  task automatic test_word(input logic [15:0] w, input bit m, input string nm);
    logic [15:0] q[$];
    int te;
    do_reset(); clear_sched(); msb_first = m;
    pv[0] = 1'b1; pd[0] = w; q = {w};
    build(q, m, 1, 0, te);
    record(te + 1);
    for (int t = 1; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL %s w=%h t=%0d ock,sdo,old,ch,ose=%b expected %b", nm, w, t, ob[t], ev[t]);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [15:0] q[$];
    logic m;
    int te;
    do_reset(); clear_sched();
    m = 1'($urandom); msb_first = m; doen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pv[i] = 1'b1; pd[i] = 16'($urandom);
      if (i < 4) q.push_back(pd[i]);
    end
    record(5);
    total++;
    if (lv[4] !== 3'd4 || fl[4] !== 1'b1 || ov[4] !== 1'b1 || ov[3] !== 1'b0 || ob[4][0] !== 1'b0)
      $display("FAIL overflow level=%0d full=%b ovf=%b prev_ovf=%b ose=%b expected 4/1/1/0/0", lv[4], fl[4], ov[4], ov[3], ob[4][0]);
    else passed++;
    ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0 || level !== 3'd4) $display("FAIL ovf_clr ovf=%b level=%0d expected 0/4", ovf, level);
    else passed++;
    doen = 1'b1; clear_sched();
    build(q, m, 0, 0, te);
    record(te + 1);
    for (int t = 0; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL drain4 t=%0d ock,sdo,old,ch,ose=%b expected %b", t, ob[t], ev[t]);
      else passed++;
    end
    total++;
    if (empty !== 1'b1) $display("FAIL drain_empty empty=%b expected 1", empty);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    int te;
    do_reset(); clear_sched(); msb_first = 1'b1;
    pv[0] = 1'b1; pd[0] = 16'h0001; pv[1] = 1'b1; pd[1] = 16'h8000;
    q = {16'h0001, 16'h8000};
    build(q, 1'b1, 1, 0, te);
    record(te + 1);
    for (int t = 1; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL back_to_back t=%0d ock,sdo,old,ch,ose=%b expected %b", t, ob[t], ev[t]);
      else passed++;
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] q[$];
    logic m;
    int te;
    do_reset(); clear_sched();
    m = 1'($urandom); msb_first = m;
    for (int i = 0; i < 6; i++) begin
      pv[i < 5 ? i : 33] = 1'b1;
      pd[i < 5 ? i : 33] = 16'($urandom);
      q.push_back(pd[i < 5 ? i : 33]);
    end
    build(q, m, 1, 0, te);
    record(te + 1);
    total++;
    if (lv[4] !== 3'd4 || fl[4] !== 1'b1 || lv[33] !== 3'd4 || ov[33] !== 1'b0)
      $display("FAIL full_pop level4=%0d full4=%b level33=%0d ovf33=%b expected 4/1/4/0", lv[4], fl[4], lv[33], ov[33]);
    else passed++;
    for (int t = 1; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL full_pop_stream t=%0d ock,sdo,old,ch,ose=%b expected %b", t, ob[t], ev[t]);
      else passed++;
    end
  endtask

  task automatic test_underrun();
    logic [15:0] q[$];
    logic m;
    int te;
    do_reset(); clear_sched();
    m = 1'($urandom); msb_first = m;
    pv[0] = 1'b1; pd[0] = 16'($urandom); q = {pd[0]};
    build(q, m, 1, 0, te);
    record(te + 1);
    for (int t = 1; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL underrun t=%0d ock,sdo,old,ch,ose=%b expected %b", t, ob[t], ev[t]);
      else passed++;
    end
    total++;
    if (un[te] !== UND) $display("FAIL underrun_unf unf=%b expected %b", un[te], UND);
    else passed++;
    clear_sched();
    pv[0] = 1'b1; pd[0] = 16'($urandom); q = {pd[0]};
    build(q, m, 1, UND ? 0 : 1, te);
    record(te + 1);
    for (int t = 1; t <= te; t++) begin
      total++;
      if (ob[t] !== ev[t]) $display("FAIL frame_continue t=%0d ock,sdo,old,ch,ose=%b expected %b", t, ob[t], ev[t]);
      else passed++;
    end
    ovf_clr = 1'b1; @(posedge clk); #1 ovf_clr = 1'b0;
    total++;
    if (unf !== 1'b0) $display("FAIL unf_clr unf=%b expected 0", unf);
    else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_async_reset();
    test_word(16'hA5F0, 1'b1, "msb_first");
    test_word(16'hA5F0, 1'b0, "lsb_first");
    for (int i = 0; i < 4; i++) test_word(16'($urandom), 1'($urandom), "rand_word");
    test_overflow();
    test_back_to_back();
    test_full_pop();
    test_underrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
